// File: rtl/seg_scan_mux_pkg.sv
// Shared definitions for the 7-segment scan driver.
//   NIBBLE_W     : bits per displayed hex digit
//   SEG_W        : segment bus width (a..g)
//   scan_state_e : slot phase, ST_BLANK (anti-ghosting gap) / ST_SHOW (digit lit)
package seg_scan_mux_pkg;

    localparam int NIBBLE_W = 4;
    localparam int SEG_W    = 7;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } scan_state_e;

endpackage

// File: rtl/seg_scan_mux_if.sv
// Value-load handshake between a producer and seg_scan_mux.
//   val_valid : producer has value_i/dp_i ready this cycle
//   val_ready : consumer shadow register is empty
//   value_i   : NUM_DIGITS hex nibbles, LSB nibble = digit 0
//   dp_i      : decimal-point enable per digit
// Modports: master = producer side, slave = display side.
interface seg_scan_mux_if #(
    parameter int NUM_DIGITS = 4
);
    import seg_scan_mux_pkg::*;

    logic                           val_valid;
    logic                           val_ready;
    logic [NUM_DIGITS*NIBBLE_W-1:0] value_i;
    logic [NUM_DIGITS-1:0]          dp_i;

    modport master (output val_valid, value_i, dp_i, input val_ready);
    modport slave  (input val_valid, value_i, dp_i, output val_ready);

endinterface

// File: rtl/seg_scan_mux_seg7.sv
// Hex nibble to 7-segment decoder, active-high segments.
//   nibble : hex digit 0..F
//   seg    : {g,f,e,d,c,b,a}, bit 0 = segment a
module seg_scan_mux_seg7
    import seg_scan_mux_pkg::*;
(
    input  logic [NIBBLE_W-1:0] nibble,
    output logic [SEG_W-1:0]    seg
);

    always_comb begin
        seg = '0;
        case (nibble)
            4'h0: seg = 7'h3F;
            4'h1: seg = 7'h06;
            4'h2: seg = 7'h5B;
            4'h3: seg = 7'h4F;
            4'h4: seg = 7'h66;
            4'h5: seg = 7'h6D;
            4'h6: seg = 7'h7D;
            4'h7: seg = 7'h07;
            4'h8: seg = 7'h7F;
            4'h9: seg = 7'h6F;
            4'hA: seg = 7'h77;
            4'hB: seg = 7'h7C;
            4'hC: seg = 7'h39;
            4'hD: seg = 7'h5E;
            4'hE: seg = 7'h79;
            4'hF: seg = 7'h71;
            default: seg = '0;
        endcase
    end

endmodule

// File: rtl/seg_scan_mux.sv
// Time-multiplexed driver for a NUM_DIGITS common-cathode 7-segment display.
// A new value is taken over the handshake into a shadow register and only
// copied to the displayed (active) register at a frame boundary, so a frame
// never mixes two values. Each digit slot is PRESCALE cycles, the first
// BLANK_CYCLES of which keep all digits off to avoid ghosting.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   ena         : scan enable; low freezes the scan and blanks the outputs
//   bus         : value-load handshake (slave side)
//   seg_o       : segments a..g of the driven digit (registered)
//   dp_o        : decimal point of the driven digit (registered)
//   digit_en_o  : one-hot digit select, zero while blanking (registered)
//   frame_tick  : one-cycle pulse after the last digit's slot ends
module seg_scan_mux
    import seg_scan_mux_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int PRESCALE     = 2500,
    parameter int BLANK_CYCLES = 16,
    parameter int LZ_SUPPRESS  = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ena,
    seg_scan_mux_if.slave         bus,
    output logic [SEG_W-1:0]      seg_o,
    output logic                  dp_o,
    output logic [NUM_DIGITS-1:0] digit_en_o,
    output logic                  frame_tick
);

    localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int VAL_W = NUM_DIGITS * NIBBLE_W;

    localparam logic [CNT_W-1:0]      CNT_LAST      = CNT_W'(PRESCALE - 1);
    localparam logic [CNT_W-1:0]      CNT_BLANK_END = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [IDX_W-1:0]      IDX_LAST      = IDX_W'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] EN_ONE        = NUM_DIGITS'(1);

    logic [CNT_W-1:0]      cnt;
    logic [IDX_W-1:0]      idx;
    scan_state_e           state_q, state_d;

    logic [VAL_W-1:0]      active_val, shadow_val;
    logic [NUM_DIGITS-1:0] active_dp,  shadow_dp;
    logic                  pending;

    logic                  slot_end, frame_end;
    logic [NUM_DIGITS-1:0] lz_mask;
    logic [NIBBLE_W-1:0]   cur_nib;
    logic [SEG_W-1:0]      cur_seg;

    logic [SEG_W-1:0]      seg_d;
    logic                  dp_d;
    logic [NUM_DIGITS-1:0] en_d;

    // Boundaries only exist while scanning; a frozen scan never ends a slot.
    assign slot_end  = ena && (cnt == CNT_LAST);
    assign frame_end = slot_end && (idx == IDX_LAST);

    assign bus.val_ready = !pending;

    // ---------------- slot prescaler and digit index ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            idx <= '0;
        end else if (ena) begin
            if (cnt == CNT_LAST) begin
                cnt <= '0;
                idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // ---------------- shadow / active value registers ----------------
    // Loading and applying are mutually exclusive (one needs pending=0, the
    // other pending=1), so a load landing on a boundary waits one frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_val <= '0;
            active_dp  <= '0;
            shadow_val <= '0;
            shadow_dp  <= '0;
            pending    <= 1'b0;
        end else begin
            if (frame_end && pending) begin
                active_val <= shadow_val;
                active_dp  <= shadow_dp;
                pending    <= 1'b0;
            end
            if (bus.val_valid && !pending) begin
                shadow_val <= bus.value_i;
                shadow_dp  <= bus.dp_i;
                pending    <= 1'b1;
            end
        end
    end

    // ---------------- leading-zero mask ----------------
    // Digit i>0 goes dark when it and every digit above it are zero and it
    // carries no decimal point; digit 0 always shows.
    always_comb begin
        lz_mask = '0;
        for (int i = 1; i < NUM_DIGITS; i++) begin
            lz_mask[i] = (LZ_SUPPRESS != 0) && !active_dp[i]
                         && ((active_val >> (i * NIBBLE_W)) == '0);
        end
    end

    assign cur_nib = active_val[idx*NIBBLE_W +: NIBBLE_W];

    seg_scan_mux_seg7 u_seg7 (
        .nibble (cur_nib),
        .seg    (cur_seg)
    );

    // ---------------- scan FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_BLANK;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        en_d    = '0;
        seg_d   = '0;
        dp_d    = 1'b0;

        if (ena) begin
            if (cnt == CNT_LAST)           state_d = ST_BLANK;
            else if (cnt == CNT_BLANK_END) state_d = ST_SHOW;
        end

        // Suppressed digits keep their enable so the scan duty stays uniform.
        if (ena && state_q == ST_SHOW) begin
            en_d  = EN_ONE << idx;
            seg_d = lz_mask[idx] ? '0 : cur_seg;
            dp_d  = active_dp[idx];
        end
    end

    // ---------------- registered outputs ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_o      <= '0;
            dp_o       <= 1'b0;
            digit_en_o <= '0;
            frame_tick <= 1'b0;
        end else begin
            seg_o      <= seg_d;
            dp_o       <= dp_d;
            digit_en_o <= en_d;
            frame_tick <= frame_end;
        end
    end

endmodule
